// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x3 keypad scanner: geometry, key codes,
// scan classification and sequencer states.
package keypad_pkg;

  localparam int KP_ROWS = 4;
  localparam int KP_COLS = 3;
  localparam int KP_KEYS = KP_ROWS * KP_COLS;

  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_HASH = 4'hB;

  // Classification of one complete 12-bit scan snapshot
  typedef enum logic [1:0] {
    SCAN_NONE,
    SCAN_SINGLE,
    SCAN_MULTI
  } scan_res_e;

  // Press/release sequencer states
  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } kp_state_e;

  // Map a (row, col) position to its key code; the bottom row holds '*', '0', '#'
  function automatic logic [3:0] kp_encode(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    if (row == 2'd3) begin
      case (col)
        2'd0:    code = KEY_STAR;
        2'd1:    code = 4'h0;
        default: code = KEY_HASH;
      endcase
    end else begin
      code = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_key_fifo.sv
// Small first-word-fall-through FIFO for 4-bit key codes.
// The head entry is visible on data_o whenever valid_o is high; a push into a
// full FIFO is accepted only if a pop happens in the same cycle.
module keypad_key_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic [3:0] data_i,
  input  logic       pop_i,
  output logic [3:0] data_o,
  output logic       valid_o,
  output logic       full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          empty;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign do_pop  = pop_i && !empty;
  assign do_push = push_i && (!full || do_pop);

  // Entry storage; contents are don't-care until written, the head is gated by empty
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; count tells full from empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign data_o  = empty ? 4'h0 : mem_q[rd_ptr_q];
  assign valid_o = !empty;
  assign full_o  = full;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x3 matrix keypad scanner: rotates one-hot column strobes, snapshots the
// synchronised rows, debounces one key at a time and queues each accepted
// press in a FWFT FIFO for the consumer.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [2:0] col_drive,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overflow,
  input  logic       clr_ovf
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DWELL_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_SCANS - 1);

  // Row synchroniser
  logic [3:0] row_meta_q;
  logic [3:0] row_s_q;

  // Column sequencing
  logic [DIV_W-1:0] dwell_q;
  logic [1:0]       col_idx_q;
  logic [2:0]       col_drive_q;
  logic [3:0]       snap_q [KP_COLS-1];
  logic             dwell_last;
  logic             scan_done;

  // Scan evaluation
  logic [KP_KEYS-1:0] scan_bits;
  logic [3:0]         ones;
  logic [1:0]         hit_row;
  logic [1:0]         hit_col;
  scan_res_e          scan_res;
  logic [3:0]         scan_code;

  // Sequencer
  kp_state_e        state_q;
  logic [3:0]       cand_q;
  logic [CNT_W-1:0] cnt_q;
  logic             held_q;
  logic             push_q;
  logic [3:0]       push_code_q;

  // FIFO side
  logic fifo_full;
  logic fifo_valid;
  logic pop;
  logic drop;
  logic ovf_q;

  // Two-flop synchroniser for the asynchronous row lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_q <= '0;
      row_s_q    <= '0;
    end else begin
      row_meta_q <= row_in;
      row_s_q    <= row_meta_q;
    end
  end

  assign dwell_last = (dwell_q == DWELL_LAST);
  assign scan_done  = dwell_last && (col_idx_q == 2'd2);

  // Dwell counter, row snapshot on the last dwell cycle and column rotation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_q     <= '0;
      col_idx_q   <= '0;
      col_drive_q <= 3'b001;
      for (int i = 0; i < KP_COLS - 1; i++) begin
        snap_q[i] <= '0;
      end
    end else if (dwell_last) begin
      dwell_q <= '0;
      // column 2 is never stored: the scan is evaluated on its live sample
      if (col_idx_q != 2'd2) begin
        snap_q[col_idx_q[0]] <= row_s_q;
      end
      col_idx_q   <= (col_idx_q == 2'd2) ? 2'd0 : col_idx_q + 2'd1;
      col_drive_q <= {col_drive_q[1:0], col_drive_q[2]};
    end else begin
      dwell_q <= dwell_q + DIV_W'(1);
    end
  end

  // Flatten to bit row*3+col, with the last column taken from the sample being captured now
  for (genvar gi = 0; gi < KP_KEYS; gi++) begin : g_bits
    if ((gi % KP_COLS) == KP_COLS - 1) begin : g_live
      assign scan_bits[gi] = row_s_q[gi / KP_COLS];
    end else begin : g_snap
      assign scan_bits[gi] = snap_q[gi % KP_COLS][gi / KP_COLS];
    end
  end

  // Count pressed positions and locate the (single) pressed key
  always_comb begin
    ones    = '0;
    hit_row = '0;
    hit_col = '0;
    for (int i = 0; i < KP_KEYS; i++) begin
      if (scan_bits[i]) begin
        ones    = ones + 4'd1;
        hit_row = 2'(i / KP_COLS);
        hit_col = 2'(i % KP_COLS);
      end
    end
    if (ones == 4'd0) begin
      scan_res = SCAN_NONE;
    end else if (ones == 4'd1) begin
      scan_res = SCAN_SINGLE;
    end else begin
      scan_res = SCAN_MULTI;
    end
    scan_code = kp_encode(hit_row, hit_col);
  end

  // Debounce sequencer, evaluated once per completed scan; push and held are registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SCAN;
      cand_q      <= '0;
      cnt_q       <= '0;
      held_q      <= 1'b0;
      push_q      <= 1'b0;
      push_code_q <= '0;
    end else begin
      push_q <= 1'b0;
      if (scan_done) begin
        case (state_q)
          ST_SCAN: begin
            if (scan_res == SCAN_SINGLE) begin
              cand_q <= scan_code;
              if (DEBOUNCE_SCANS == 1) begin
                push_q      <= 1'b1;
                push_code_q <= scan_code;
                held_q      <= 1'b1;
                state_q     <= ST_HELD;
              end else begin
                cnt_q   <= CNT_W'(1);
                state_q <= ST_DEBOUNCE;
              end
            end
          end
          ST_DEBOUNCE: begin
            if (scan_res == SCAN_SINGLE) begin
              if (scan_code == cand_q) begin
                if (cnt_q == CNT_LAST) begin
                  push_q      <= 1'b1;
                  push_code_q <= cand_q;
                  held_q      <= 1'b1;
                  state_q     <= ST_HELD;
                end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
                end
              end else begin
                cand_q <= scan_code;
                cnt_q  <= CNT_W'(1);
              end
            end else begin
              state_q <= ST_SCAN;
            end
          end
          ST_HELD: begin
            // no rollover: only a clean empty scan starts the release
            if (scan_res == SCAN_NONE) begin
              if (DEBOUNCE_SCANS == 1) begin
                held_q  <= 1'b0;
                state_q <= ST_SCAN;
              end else begin
                cnt_q   <= CNT_W'(1);
                state_q <= ST_RELEASE;
              end
            end
          end
          default: begin
            if (scan_res == SCAN_NONE) begin
              if (cnt_q == CNT_LAST) begin
                held_q  <= 1'b0;
                state_q <= ST_SCAN;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end else begin
              state_q <= ST_HELD;
            end
          end
        endcase
      end
    end
  end

  assign pop  = key_ready;
  assign drop = push_q && fifo_full && !(fifo_valid && key_ready);

  keypad_key_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push_q),
    .data_i (push_code_q),
    .pop_i  (pop),
    .data_o (key_code),
    .valid_o(fifo_valid),
    .full_o (fifo_full)
  );

  // Sticky overflow flag; a clear in the same cycle as a drop wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (clr_ovf) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end
  end

  assign col_drive = col_drive_q;
  assign key_valid = fifo_valid;
  assign key_held  = held_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl with a keypad matrix model and a
// scan-level reference model of press/release acceptance and the key queue.
module tb_keypad_scan_ctrl;

  localparam int SCAN_DIV = 4;
  localparam int DS       = 2;
  localparam int DEPTH    = 4;
  localparam int SCAN_CYC = 3 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row_in;
  logic [2:0] col_drive;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready = 1'b0;
  logic       key_held;
  logic       overflow;
  logic       clr_ovf = 1'b0;

  // keys[r*3+c] = 1 while key (r,c) is physically down
  logic [11:0] keys = '0;

  int checks = 0;
  int failures = 0;

  // Keypad legend in row-major order: 1 2 3 / 4 5 6 / 7 8 9 / * 0 #
  logic [3:0] keytab [12] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                              4'h7, 4'h8, 4'h9, 4'hA, 4'h0, 4'hB};

  // Reference model state
  bit          m_held;
  int          m_run;
  logic [3:0]  m_code;
  int          m_cnt;
  bit          m_ovf;
  logic [3:0]  exp_q[$];
  logic [3:0]  obs_q[$];

  always #5 clk = ~clk;

  keypad_scan_ctrl #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DS),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .row_in   (row_in),
    .col_drive(col_drive),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .key_held (key_held),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  // Matrix: a pressed key connects its driven column onto its row
  always_comb begin
    row_in = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (keys[r*3+c] && col_drive[c]) row_in[r] = 1'b1;
      end
    end
  end

  // Consumer: record every accepted handshake
  always @(negedge clk) begin
    if (rst_n && key_valid && key_ready) obs_q.push_back(key_code);
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    m_held = 0;
    m_run  = 0;
    m_code = '0;
    m_cnt  = 0;
    m_ovf  = 0;
    exp_q.delete();
    obs_q.delete();
  endtask

  // One full scan seen by the model: run-length rules for press and release
  task automatic model_scan(input logic [11:0] snap);
    int pc;
    int idx;
    logic [3:0] code;
    pc  = $countones(snap);
    idx = 0;
    for (int i = 0; i < 12; i++) if (snap[i]) idx = i;
    code = keytab[idx];
    if (!m_held) begin
      if (pc == 1) begin
        if (m_run > 0 && code == m_code) m_run++;
        else begin
          m_code = code;
          m_run  = 1;
        end
        if (m_run == DS) begin
          m_held = 1;
          m_run  = 0;
          if (key_ready) exp_q.push_back(m_code);
          else if (m_cnt == DEPTH) m_ovf = 1;
          else begin
            exp_q.push_back(m_code);
            m_cnt++;
          end
        end
      end else begin
        m_run = 0;
      end
    end else begin
      if (pc == 0) begin
        m_run++;
        if (m_run == DS) begin
          m_held = 0;
          m_run  = 0;
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  // Hold a key set for exactly one scan; called on a scan boundary
  task automatic run_scan(input logic [11:0] k);
    keys = k;
    repeat (SCAN_CYC) @(posedge clk);
    #1;
    model_scan(k);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    keys  = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [2:0] exp_col;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (col_drive !== 3'b001) begin failures++; $display("FAIL reset_col got=%b want=001", col_drive); end
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", key_valid); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b want=0", overflow); end
    checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL reset_held got=%b want=0", key_held); end
    checks++; if (key_code !== 4'h0) begin failures++; $display("FAIL reset_code got=%h want=0", key_code); end
    model_reset();
    rst_n = 1'b1;
    exp_col = 3'b001;
    for (int i = 0; i < 3; i++) begin
      repeat (SCAN_DIV - 1) @(posedge clk);
      #1;
      checks++; if (col_drive !== exp_col) begin failures++; $display("FAIL dwell_col step=%0d got=%b want=%b", i, col_drive, exp_col); end
      @(posedge clk);
      #1;
      exp_col = {exp_col[1:0], exp_col[2]};
      checks++; if (col_drive !== exp_col) begin failures++; $display("FAIL rotate_col step=%0d got=%b want=%b", i, col_drive, exp_col); end
    end
    $display("test_reset done");
  endtask

  task automatic test_single_press();
    apply_reset();
    key_ready = 1'b1;
    for (int s = 0; s < 8; s++) begin
      run_scan((s < 5) ? 12'h010 : 12'h000);
      checks++; if (key_held !== m_held) begin failures++; $display("FAIL press_held scan=%0d got=%b want=%b", s, key_held, m_held); end
    end
    checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL press_count got=%0d want=1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      checks++; if (obs_q[0] !== 4'h5) begin failures++; $display("FAIL press_code got=%h want=5", obs_q[0]); end
    end
    $display("test_single_press pops=%0d", obs_q.size());
  endtask

  task automatic test_bounce();
    logic [11:0] seq [8] = '{12'h800, 12'h000, 12'h800, 12'h800, 12'h800, 12'h000, 12'h000, 12'h000};
    apply_reset();
    key_ready = 1'b1;
    for (int s = 0; s < 8; s++) begin
      run_scan(seq[s]);
      checks++; if (key_held !== m_held) begin failures++; $display("FAIL bounce_held scan=%0d got=%b want=%b", s, key_held, m_held); end
      if (s == 2) begin
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL bounce_early got=%0d want=0", obs_q.size()); end
      end
    end
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL bounce_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    if (obs_q.size() > 0) begin
      checks++; if (obs_q[0] !== 4'hB) begin failures++; $display("FAIL bounce_code got=%h want=b", obs_q[0]); end
    end
    $display("test_bounce pops=%0d", obs_q.size());
  endtask

  task automatic test_ghost();
    apply_reset();
    key_ready = 1'b1;
    for (int s = 0; s < 3; s++) begin
      run_scan(12'h101);
      checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL ghost_held scan=%0d got=%b want=0", s, key_held); end
    end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL ghost_push got=%0d want=0", obs_q.size()); end
    for (int s = 0; s < 5; s++) begin
      run_scan((s < 2) ? 12'h001 : 12'h000);
      checks++; if (key_held !== m_held) begin failures++; $display("FAIL ghost_rel_held scan=%0d got=%b want=%b", s, key_held, m_held); end
    end
    checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL ghost_count got=%0d want=1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      checks++; if (obs_q[0] !== 4'h1) begin failures++; $display("FAIL ghost_code got=%h want=1", obs_q[0]); end
    end
    $display("test_ghost pops=%0d", obs_q.size());
  endtask

  task automatic test_overflow();
    apply_reset();
    key_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      for (int s = 0; s < 4; s++) run_scan((s < 2) ? (12'h001 << k) : 12'h000);
      $display("overflow press=%0d queued_model=%0d", k + 1, m_cnt);
    end
    checks++; if (key_valid !== 1'b1) begin failures++; $display("FAIL ovf_valid got=%b want=1", key_valid); end
    checks++; if (key_code !== exp_q[0]) begin failures++; $display("FAIL ovf_head got=%h want=%h", key_code, exp_q[0]); end
    checks++; if (overflow !== m_ovf) begin failures++; $display("FAIL ovf_flag got=%b want=%b", overflow, m_ovf); end
    @(posedge clk);
    #1;
    checks++; if (key_code !== 4'h1) begin failures++; $display("FAIL ovf_hold_head got=%h want=1", key_code); end
    clr_ovf = 1'b1;
    @(posedge clk);
    #1;
    clr_ovf = 1'b0;
    m_ovf = 0;
    checks++; if (overflow !== m_ovf) begin failures++; $display("FAIL ovf_clear got=%b want=0", overflow); end
    key_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    m_cnt = 0;
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL drain_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL drain_code idx=%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
      checks++; if (obs_q[i] !== 4'(i + 1)) begin failures++; $display("FAIL drain_order idx=%0d got=%h want=%0d", i, obs_q[i], i + 1); end
    end
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b want=0", key_valid); end
    $display("test_overflow drained=%0d", obs_q.size());
  endtask

  task automatic test_reset_mid();
    apply_reset();
    key_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 4; s++) run_scan((s < 2) ? (12'h001 << k) : 12'h000);
    end
    run_scan(12'h004);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (key_valid !== (m_cnt > 0)) begin failures++; $display("FAIL mid_pre_valid got=%b want=%b", key_valid, m_cnt > 0); end
    rst_n = 1'b0;
    #1;
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b want=0", key_valid); end
    checks++; if (col_drive !== 3'b001) begin failures++; $display("FAIL mid_col got=%b want=001", col_drive); end
    checks++; if (key_code !== 4'h0) begin failures++; $display("FAIL mid_code got=%h want=0", key_code); end
    repeat (2) @(posedge clk);
    #1;
    keys = '0;
    model_reset();
    key_ready = 1'b1;
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) begin
      run_scan(12'h000);
      checks++; if (key_held !== m_held) begin failures++; $display("FAIL mid_held scan=%0d got=%b want=%b", s, key_held, m_held); end
    end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL mid_stale got=%0d want=0", obs_q.size()); end
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL mid_post_valid got=%b want=0", key_valid); end
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    logic [11:0] k;
    logic [11:0] prev;
    int r;
    int a;
    int b;
    apply_reset();
    key_ready = 1'b1;
    prev = '0;
    for (int s = 0; s < 62; s++) begin
      r = $urandom_range(0, 9);
      if (s >= 60) k = '0;
      else if (r < 5) k = prev;
      else if (r < 7) k = '0;
      else if (r < 9) k = 12'h001 << $urandom_range(0, 11);
      else begin
        a = $urandom_range(0, 11);
        b = (a + 1 + $urandom_range(0, 10)) % 12;
        k = (12'h001 << a) | (12'h001 << b);
      end
      prev = k;
      run_scan(k);
      checks++; if (key_held !== m_held) begin failures++; $display("FAIL rand_held scan=%0d keys=%h got=%b want=%b", s, k, key_held, m_held); end
    end
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_code idx=%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
    $display("test_random presses=%0d", exp_q.size());
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_press();
    test_bounce();
    test_ghost();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Sequencer for the 4x3 matrix keypad.
- Drives one-hot column strobes, samples the row lines, and resolves the pressed key.
- Debounces the key and reports each press exactly once.
- Buffers key codes in a small FIFO, read by the consumer (display/ALU front-end) over a valid/ready handshake.
- Key encoding is identical to the keypad decoder block: digits 1-9 and 0 map to their value, '*' = 4'hA, '#' = 4'hB.

Parameters:
- SCAN_DIV, 1000: clock cycles each column stays driven (dwell); legal range is 4 or more.
- DEBOUNCE_SCANS, 4: consecutive identical full scans needed to accept a press or a release; legal range is 1 or more.
- FIFO_DEPTH, 4: key FIFO entries; must be a power of 2, 2 or more.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- row_in  in  4  keypad rows, active-high; asynchronous to clk.
- col_drive  out  3  one-hot column strobe, active-high.
- key_code  out  4  FIFO head code.
- key_valid  out  1  FIFO not empty.
- key_ready  in  1  consumer accepts head this cycle.
- key_held  out  1  a debounced key is currently down.
- overflow  out  1  sticky: a press was dropped because the FIFO was full.
- clr_ovf  in  1  clears overflow; wins over a same-cycle set.

Behaviour:
- Reset values: col_drive=3'b001, key_code=0, key_valid=0, key_held=0, overflow=0. FIFO is empty, counters are 0, state is SCAN.
- Reset mid-operation discards all FIFO contents and any in-progress debounce.
- row_in passes through a 2-flop synchronizer (row_s).
- Column sequencing:
  - Dwell counter counts 0..SCAN_DIV-1.
  - On the last dwell cycle, row_s is sampled into snap[col], then col_drive rotates 001->010->100->001.
  - A full scan is 3*SCAN_DIV cycles; the scan completes on the cycle col 2 is sampled.
- Scan evaluation, performed once per completed scan on the 12-bit snapshot:
  - NONE: all bits 0.
  - SINGLE: exactly one bit set. Code = row*3+col+1 for rows 0-2; row 3 gives col0=4'hA, col1=4'h0, col2=4'hB.
  - MULTI: 2 or more bits set (ghosting). Treated as neither press nor release.
- FSM states: SCAN, DEBOUNCE, HELD, RELEASE. stable_cnt counts consecutive qualifying scans.
  - SCAN: on SINGLE, set cand=code, stable_cnt=1, go DEBOUNCE (if DEBOUNCE_SCANS=1, go directly to the accept path). Otherwise stay.
  - DEBOUNCE:
    - SINGLE with code==cand: stable_cnt++.
    - SINGLE with a different code: cand=new code, stable_cnt=1.
    - NONE or MULTI: return to SCAN.
    - When stable_cnt reaches DEBOUNCE_SCANS: push cand, go HELD.
  - HELD: key_held=1. On NONE, set stable_cnt=1 and go RELEASE. SINGLE of the same or another key, or MULTI, stays (no rollover). Nothing is pushed.
  - RELEASE: key_held stays 1. NONE increments stable_cnt; at DEBOUNCE_SCANS go SCAN and key_held=0. Anything else returns to HELD.
- Push latency: the accepted code appears on key_code/key_valid the cycle after the push when the FIFO was empty.
- FIFO:
  - First-word-fall-through; pop on key_valid & key_ready.
  - Push when full drops the new code and sets overflow for one push event (sticky until clr_ovf).
  - A simultaneous push and pop when full both succeed; no overflow.
  - Pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH; a count register of width log2(FIFO_DEPTH)+1 distinguishes full from empty.
- key_code is held stable while key_valid=1 and key_ready=0.

Decomposition:
- Shared package keypad_pkg:
  - Constants: KP_ROWS=4, KP_COLS=3, KEY_STAR=4'hA, KEY_HASH=4'hB.
  - Encode function (row,col)->code.
  - Scan result typedef {NONE, SINGLE, MULTI}.
  - FSM state typedef.
- One sub-module: keypad_key_fifo (parameter DEPTH, width 4, FWFT, full/empty/count).

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=2, FIFO_DEPTH=4; keypad model drives row bit r high while col_drive[c]=1 and key (r,c) is down):
- Reset check: with rst_n low, col_drive=001, key_valid=0, overflow=0. After release, col_drive rotates 001->010->100 every 4 cycles.
- Press key (1,1), hold 5 scans, release 3 scans, key_ready=1 -> exactly one pop with key_code=4'h5. key_held rises after scan 2 and falls after 2 empty scans.
- Bounce key (3,2): present 1 scan, absent 1 scan, present 1 scan -> no push. Hold 2 more scans -> one push, key_code=4'hB.
- Keys (0,0) and (2,2) held together -> no push, key_held=0. Release (2,2) -> after 2 scans, push 4'h1.
- key_ready=0, five distinct debounced presses 1,2,3,4,5 -> FIFO holds 1,2,3,4 and overflow=1. Assert clr_ovf -> overflow=0. Drain yields 1,2,3,4 in order.
- Assert rst_n=0 mid-DEBOUNCE with 2 entries queued -> key_valid=0, col_drive=001. No stale code after reset release with no key down.
